// File: rtl/m72_pkg.sv
// Shared M72 constants and types.
// Holds the NVRAM upload index, uploader FSM states and byte-lane helper.
package m72_pkg;

  localparam logic [7:0] NVRAM_IOCTL_INDEX = 8'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } nvram_up_state_t;

  // Little-endian lane pick: lsb=0 is the low byte.
  function automatic logic [7:0] byte_sel(
    input logic [15:0] w,
    input logic        lsb
  );
    return lsb ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/nvram_autosave_timer.sv
// Dirty flag plus write-quiet counter for auto-upload requests.
// Used by nvram_uploader only when NVRAM_AUTOSAVE_EN is defined.
module nvram_autosave_timer #(
  parameter logic [31:0] QUIET_CYCLES = 32'd3_200_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic save_wr,
  input  logic upload_act,
  output logic upload_req
);

  logic        dirty_q, dirty_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d;

  always_comb begin
    dirty_d = dirty_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    if (save_wr) begin
      dirty_d = 1'b1;
      cnt_d   = '0;
    end else if (dirty_q && !upload_act) begin
      if (cnt_q == QUIET_CYCLES - 32'd1) begin
        req_d   = 1'b1;
        dirty_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty_q <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign upload_req = req_q;

endmodule

// File: rtl/nvram_uploader.sv
// HPS save-file upload reader: ioctl byte reads served from SDRAM ch3.
// Auto-upload requests are built in when NVRAM_AUTOSAVE_EN is defined.
module nvram_uploader
  import m72_pkg::*;
#(
  parameter logic [7:0]  INDEX        = NVRAM_IOCTL_INDEX,
  parameter logic [23:0] BASE_WADDR   = 24'h0F_0000,
  parameter logic [24:0] SIZE         = 25'h4000,
  parameter logic [31:0] QUIET_CYCLES = 32'd3_200_000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        ioctl_upload_req,
  output logic [23:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_rdy,
  input  logic [15:0] mem_dout,
  input  logic        save_wr,
  output logic        busy
);

  nvram_up_state_t state_q, state_d;

  logic [7:0]  din_q, din_d;
  logic        wait_q, wait_d;
  logic        req_q, req_d;
  logic [23:0] maddr_q, maddr_d;
  logic        up_q;
  logic        cvalid_q, cvalid_d;
  logic [23:0] ctag_q, ctag_d;
  logic [15:0] cdata_q, cdata_d;
  logic        lsb_q, lsb_d;

  logic        act;
  logic        up_rise;
  logic [23:0] waddr;
  logic        hit;

  assign act     = ioctl_upload && (ioctl_index == INDEX);
  assign up_rise = ioctl_upload && !up_q;
  assign waddr   = ioctl_addr[24:1];
  // A write in the same cycle defeats the hit.
  assign hit     = cvalid_q && (ctag_q == waddr) && !save_wr;

  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    wait_d   = wait_q;
    req_d    = req_q;
    maddr_d  = maddr_q;
    cvalid_d = cvalid_q;
    ctag_d   = ctag_q;
    cdata_d  = cdata_q;
    lsb_d    = lsb_q;
    unique case (state_q)
      IDLE: begin
        if (ioctl_rd && act) begin
          if (ioctl_addr >= SIZE) begin
            din_d = 8'hFF;
          end else if (hit) begin
            din_d = byte_sel(cdata_q, ioctl_addr[0]);
          end else begin
            lsb_d    = ioctl_addr[0];
            maddr_d  = BASE_WADDR + waddr;
            ctag_d   = waddr;
            cvalid_d = 1'b0;
            req_d    = 1'b1;
            wait_d   = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      FETCH: begin
        if (mem_rdy) begin
          cdata_d  = mem_dout;
          cvalid_d = 1'b1;
          din_d    = byte_sel(mem_dout, lsb_q);
          req_d    = 1'b0;
          wait_d   = 1'b0;
          state_d  = IDLE;
        end else if (!act) begin
          wait_d  = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Hold the request so ch3 never returns an orphaned word.
        if (mem_rdy) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        wait_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (up_rise || save_wr) cvalid_d = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      din_q    <= '0;
      wait_q   <= 1'b0;
      req_q    <= 1'b0;
      maddr_q  <= '0;
      up_q     <= 1'b0;
      cvalid_q <= 1'b0;
      ctag_q   <= '0;
      cdata_q  <= '0;
      lsb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      maddr_q  <= maddr_d;
      up_q     <= ioctl_upload;
      cvalid_q <= cvalid_d;
      ctag_q   <= ctag_d;
      cdata_q  <= cdata_d;
      lsb_q    <= lsb_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = maddr_q;
  assign busy       = (state_q != IDLE);

`ifdef NVRAM_AUTOSAVE_EN
  nvram_autosave_timer #(
    .QUIET_CYCLES (QUIET_CYCLES)
  ) u_timer (
    .clk        (clk_sys),
    .rst_n      (reset_n),
    .save_wr    (save_wr),
    .upload_act (act),
    .upload_req (ioctl_upload_req)
  );
`else
  logic unused_quiet;
  assign unused_quiet     = ^QUIET_CYCLES;
  assign ioctl_upload_req = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_uploader.sv
// Directed bench for nvram_uploader.
// Autosave checks run only when NVRAM_AUTOSAVE_EN is defined.
module tb_nvram_uploader;

  localparam logic [23:0] BASE = 24'h0F_0000;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic        mem_rdy = 1'b0;
  logic [15:0] mem_dout = '0;
  logic        save_wr = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wait_cnt = 0;
  int req_rises = 0;
  int upreq_cnt = 0;
  logic req_prev = 1'b0;
  logic [23:0] last_addr = '0;

  nvram_uploader #(
    .QUIET_CYCLES (32'd10)
  ) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_rd         (ioctl_rd),
    .ioctl_addr       (ioctl_addr),
    .ioctl_din        (ioctl_din),
    .ioctl_wait       (ioctl_wait),
    .ioctl_upload_req (ioctl_upload_req),
    .mem_addr         (mem_addr),
    .mem_req          (mem_req),
    .mem_rdy          (mem_rdy),
    .mem_dout         (mem_dout),
    .save_wr          (save_wr),
    .busy             (busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (ioctl_wait) wait_cnt++;
    if (mem_req && !req_prev) req_rises++;
    req_prev = mem_req;
    if (ioctl_upload_req) upreq_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic rd(input logic [24:0] a);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd   = 1'b0;
  endtask

  task automatic serve(input logic [15:0] w, input int lat);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    check("req_seen", {31'd0, mem_req}, 32'd1);
    last_addr = mem_addr;
    repeat (lat) step();
    mem_rdy  = 1'b1;
    mem_dout = w;
    step();
    mem_rdy  = 1'b0;
  endtask

  initial begin
    int r0;
    int k;
    int got_k;
    step();
    check("rst_din", {24'd0, ioctl_din}, 32'd0);
    check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    check("rst_upreq", {31'd0, ioctl_upload_req}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", {8'd0, mem_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    step();
    reset_n = 1'b1;
    step();

    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    step();
    wait_cnt = 0;
    r0 = req_rises;
    rd(25'd0);
    serve(16'hBEEF, 3);
    check("miss0_din", {24'd0, ioctl_din}, 32'hEF);
    check("miss0_wait", {31'd0, ioctl_wait}, 32'd0);
    check("miss0_req", {31'd0, mem_req}, 32'd0);
    check("miss0_waitcyc", wait_cnt, 32'd4);
    check("miss0_fetch", req_rises - r0, 32'd1);
    check("miss0_addr", {8'd0, last_addr}, {8'd0, BASE});

    rd(25'd1);
    check("hit1_din", {24'd0, ioctl_din}, 32'hBE);
    check("hit1_wait", wait_cnt, 32'd4);
    check("hit1_fetch", req_rises - r0, 32'd1);

    rd(25'h4000);
    check("oor_din", {24'd0, ioctl_din}, 32'hFF);
    check("oor_wait", {31'd0, ioctl_wait}, 32'd0);
    repeat (3) step();
    check("oor_fetch", req_rises - r0, 32'd1);

    ioctl_index = 8'd0;
    rd(25'd2);
    repeat (3) step();
    check("idx_fetch", req_rises - r0, 32'd1);
    check("idx_din", {24'd0, ioctl_din}, 32'hFF);
    ioctl_index = 8'd4;

    rd(25'd2);
    serve(16'h1234, 1);
    check("a2_din", {24'd0, ioctl_din}, 32'h34);
    check("a2_addr", {8'd0, last_addr}, {8'd0, BASE + 24'd1});
    save_wr = 1'b1;
    step();
    save_wr = 1'b0;
    rd(25'd3);
    serve(16'h5678, 1);
    check("a3_din", {24'd0, ioctl_din}, 32'h56);
    check("a3_addr", {8'd0, last_addr}, {8'd0, BASE + 24'd1});
    check("a23_fetch", req_rises - r0, 32'd3);

    save_wr = 1'b1;
    rd(25'd2);
    save_wr = 1'b0;
    serve(16'hA1B2, 1);
    check("wrwin_din", {24'd0, ioctl_din}, 32'hB2);
    check("wrwin_fetch", req_rises - r0, 32'd4);
    rd(25'd3);
    check("hit3_din", {24'd0, ioctl_din}, 32'hA1);
    check("hit3_fetch", req_rises - r0, 32'd4);

    rd(25'd4);
    check("drn_req0", {31'd0, mem_req}, 32'd1);
    ioctl_upload = 1'b0;
    step();
    check("drn_wait", {31'd0, ioctl_wait}, 32'd0);
    check("drn_busy", {31'd0, busy}, 32'd1);
    step();
    check("drn_hold", {31'd0, mem_req}, 32'd1);
    mem_rdy  = 1'b1;
    mem_dout = 16'hDEAD;
    step();
    mem_rdy  = 1'b0;
    check("drn_req", {31'd0, mem_req}, 32'd0);
    check("drn_idle", {31'd0, busy}, 32'd0);
    check("drn_din", {24'd0, ioctl_din}, 32'hA1);

    ioctl_upload = 1'b1;
    step();
    rd(25'd6);
    check("rstf_req0", {31'd0, mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstf_req", {31'd0, mem_req}, 32'd0);
    check("rstf_wait", {31'd0, ioctl_wait}, 32'd0);
    check("rstf_busy", {31'd0, busy}, 32'd0);
    check("rstf_din", {24'd0, ioctl_din}, 32'd0);
    check("rstf_addr", {8'd0, mem_addr}, 32'd0);
    step();
    reset_n = 1'b1;
    ioctl_upload = 1'b0;
    step();

    r0 = upreq_cnt;
    got_k = -1;
    save_wr = 1'b1;
    step();
    save_wr = 1'b0;
    repeat (4) step();
    save_wr = 1'b1;
    step();
    save_wr = 1'b0;
    for (k = 1; k <= 20; k++) begin
      step();
      if (ioctl_upload_req && got_k < 0) got_k = k;
    end
    repeat (30) step();
`ifdef NVRAM_AUTOSAVE_EN
    check("auto_time", got_k, 32'd10);
    check("auto_count", upreq_cnt - r0, 32'd1);
`else
    check("auto_none", upreq_cnt - r0, 32'd0);
    check("auto_time", got_k, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/nvram_uploader.md
# nvram_uploader

Serves the HPS upload path (save-file read-back) for the M72 core. It is the reader-side counterpart of the ROM download path. On each `ioctl_rd` during an upload of its index, it fetches the addressed 16-bit word from SDRAM channel 3 over a req/rdy port and returns the addressed byte on `ioctl_din`, stalling hps_io with `ioctl_wait` while the fetch is in flight. It sits in `emu` between `hps_io` and the ch3 multiplexer, alongside `rom_loader`.

## Interface
Parameters:
- `INDEX`, 8'd4: `ioctl_index` value this block answers.
- `BASE_WADDR`, 24'h0F_0000: SDRAM word address of save-region byte 0.
- `SIZE`, 25'h4000: save-region length in bytes (even).
- `QUIET_CYCLES`, 32'd3_200_000: write-quiet interval before an auto-upload request (100 ms at 32 MHz). Only used with the macro enabled.

Ports:
- `clk_sys` in 1: system clock (CLK_32M).
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_upload` in 1: upload in progress.
- `ioctl_index` in 8: upload target index.
- `ioctl_rd` in 1: one-cycle byte read strobe.
- `ioctl_addr` in 25: byte address of the read.
- `ioctl_din` out 8: returned byte.
- `ioctl_wait` out 1: stall to hps_io.
- `ioctl_upload_req` out 1: one-cycle request for the HPS to start an upload.
- `mem_addr` out 24: SDRAM word address ([24:1]).
- `mem_req` out 1: read request, held high until `mem_rdy`.
- `mem_rdy` in 1: one-cycle completion; `mem_dout` is valid in the same cycle.
- `mem_dout` in 16: read word.
- `save_wr` in 1: one-cycle pulse whenever the game writes the save region.
- `busy` out 1: high in FETCH or DRAIN.

## Operation
- An upload is active when `ioctl_upload && ioctl_index==INDEX`. Reads are ignored when the upload is not active.
- Byte order is little-endian: `ioctl_addr[0]=0` selects `mem_dout[7:0]`, `ioctl_addr[0]=1` selects `mem_dout[15:8]`.
- `mem_addr = BASE_WADDR + ioctl_addr[24:1]`. The sum is 24 bits and wraps modulo 2^24.
- A one-word cache holds a tag and data with a valid bit. The valid bit is cleared on the rising edge of `ioctl_upload` and on `save_wr`.
- FSM states:
  - IDLE: on a valid `ioctl_rd`:
    - If `addr>=SIZE`: `ioctl_din<=8'hFF`, no fetch, stay in IDLE.
    - Else on a cache hit: `ioctl_din<=` the cached byte, stay in IDLE.
    - Else on a miss: latch `addr`, set `mem_req=1` and `ioctl_wait=1`, go to FETCH.
  - FETCH: on `mem_rdy`, fill the cache, drive the selected byte to `ioctl_din`, drop `mem_req` and `ioctl_wait`, go to IDLE. If the upload goes inactive first, drop `ioctl_wait` and go to DRAIN.
  - DRAIN: keep `mem_req` high until `mem_rdy`, discard the data, go to IDLE. This prevents an orphaned ch3 response.
- An `ioctl_rd` that arrives in FETCH or DRAIN is ignored.

## Timing
- Reset values: `ioctl_din=0`, `ioctl_wait=0`, `ioctl_upload_req=0`, `mem_req=0`, `mem_addr=0`, `busy=0`. The cache is invalid, the dirty flag and counter are 0, and the FSM is in IDLE.
- Hit or out-of-range read: `ioctl_din` is valid 1 cycle after `ioctl_rd`, and `ioctl_wait` stays 0.
- Miss: `ioctl_wait` and `mem_req` rise 1 cycle after `ioctl_rd`. Both fall, and `ioctl_din` updates, 1 cycle after `mem_rdy`.
- `save_wr` in the same cycle as a hit: the write wins. The read is treated as a miss.
- Reset mid-fetch: all outputs clear asynchronously and the pending ch3 request is abandoned. The ch3 owner resets in the same domain.

## Configuration
- `NVRAM_AUTOSAVE_EN` defined:
  - A dirty flag is set by `save_wr`, and each `save_wr` reloads the quiet counter to 0.
  - The counter advances only while dirty and not in an active upload.
  - When the counter reaches `QUIET_CYCLES-1`, `ioctl_upload_req` pulses for 1 cycle and the dirty flag clears.
  - A `save_wr` during an upload re-arms the dirty flag, so a new request follows after the upload ends.
- `NVRAM_AUTOSAVE_EN` undefined:
  - `ioctl_upload_req` is tied 0 and the counter and dirty logic are absent.
  - `save_wr` only invalidates the cache.

## Structure
- `m72_pkg` holds the `NVRAM_IOCTL_INDEX` constant and the `nvram_up_state_t` enum (IDLE, FETCH, DRAIN).
- One sub-module, `nvram_autosave_timer` (dirty flag plus quiet counter), is instantiated only under the macro.

## Test plan
- Reads at addr 0 then 1, mem word 16'hBEEF, `mem_rdy` 3 cycles after req -> `din` 8'hEF with one fetch and `wait` high 4 cycles. Then `din` 8'hBE with no fetch and `wait` 0.
- Read at addr `SIZE` (16'h4000) -> `din` 8'hFF 1 cycle later, `mem_req` never asserted.
- Wrong `ioctl_index` (0) with `ioctl_rd` -> no `mem_req`, `din` unchanged.
- `save_wr` between reads of addr 2 and 3 -> two fetches, both at `mem_addr` `BASE_WADDR+1`.
- `ioctl_upload` falls in FETCH -> `wait` 0 next cycle, `mem_req` held until `mem_rdy`, FSM back in IDLE, `busy` 0.
- With `NVRAM_AUTOSAVE_EN` and `QUIET_CYCLES`=10: `save_wr` at t0 and t5 -> a single `ioctl_upload_req` pulse at t15, and no further pulses.
